div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle controller for signed and unsigned integer division and remainder, replacing the single-cycle combinational divide path in the core ALU. It captures operands when the decoder flags a divide instruction and runs a one-bit-per-cycle restoring divider. While running it drives a stall that holds the program counter and register-file write. When the result is ready it presents it for a single retire cycle.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces reset state
- start  in  1  level; high while the instruction in execute is a divide/remainder
- op_signed  in  1  1 = signed (div/rem), 0 = unsigned (divu/remu)
- op_rem  in  1  1 = return remainder, 0 = return quotient
- dividend  in  WIDTH  SrcA
- divisor  in  WIDTH  SrcB
- result  out  WIDTH  registered quotient or remainder
- done  out  1  one-cycle pulse; result valid, instruction may retire
- busy  out  1  high in RUN and FIX
- stall  out  1  combinational: start & ~done; gates the PC register and RegWrite

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - start=1 captures op_signed, op_rem, |dividend|, |divisor|, and sign flags.
  - Magnitudes are taken only if op_signed=1; otherwise operands are used raw.
  - Loads the step counter with WIDTH-1 and goes to RUN.
- **Special cases in IDLE**
  - Divide by zero (divisor==0): skip to DONE with quotient=all-ones and remainder=dividend (RISC-V semantics).
  - Signed overflow (op_signed, dividend=100…0, divisor=all-ones): skip to DONE with quotient=dividend and remainder=0.
- **RUN**
  - Each cycle does one restoring step: shift partial remainder (WIDTH+1 bits) left, bringing in the next dividend bit MSB-first.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore.
  - When the counter reaches 0, go to FIX.
- **FIX**
  - Negate the quotient if op_signed and the operand signs differ.
  - Negate the remainder if op_signed and the dividend was negative.
  - Load result per op_rem and go to DONE.
- **DONE**
  - done=1 for exactly one cycle; always returns to IDLE next edge.
  - If start is still high in the following IDLE cycle, it is a new instruction and is captured again.
- start and operand changes during RUN/FIX/DONE are ignored; the captured copies are used.
- result holds its value until the next FIX or special-case load.
- Arithmetic is modulo 2^WIDTH. Negation is two's complement. The WIDTH+1-bit partial remainder prevents trial-subtract overflow.

## Timing
- Reset values: state=IDLE, result=0, done=0, busy=0, counter=0, captured operands=0.
- stall is combinational and therefore 0 in reset unless start=1.
- Cycle numbering: cycle 0 is the cycle in which start is sampled high in IDLE.
- Normal latency:
  - RUN occupies cycles 1..WIDTH.
  - FIX occupies cycle WIDTH+1.
  - done=1 in cycle WIDTH+2 (34 for WIDTH=32).
  - Back in IDLE at cycle WIDTH+3.
- Special-case latency: done=1 in cycle 1.
- stall is high in cycles 0..WIDTH+1 and low in the done cycle, so the PC advances on the edge ending the done cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The partial result is discarded and no done is issued.

## Structure
- Package div_pkg holds:
  - state enum div_state_t {IDLE, RUN, FIX, DONE}
  - constant DIV_STEPS = WIDTH
  - special-case result constants (all-ones quotient, zero remainder)
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once; the FSM iterates it.

## Test plan
- Unsigned, op_rem=0, 100/7 → result=14 (0x0000000E), done in cycle 34, stall high cycles 0–33.
- Unsigned, op_rem=1, 100/7 → result=2 (0x00000002), done in cycle 34.
- Signed, op_rem=0, −100/7 → 0xFFFFFFF2 (−14).
- Signed, op_rem=1, −100/7 → 0xFFFFFFFE (−2).
- Signed, op_rem=0, 100/−7 → 0xFFFFFFF2.
- Divide by zero, 0x12345678/0 → quotient 0xFFFFFFFF, remainder 0x12345678, done in cycle 1.
- Signed overflow, 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0, done in cycle 1.
- Reset pulled low in cycle 10 of a 100/7 run → result=0, busy=0, done=0 immediately. A fresh 9/3 then yields 3 in cycle 34 with no spurious done.
- Operand changes during RUN plus back-to-back start → first result is unaffected. The second operation starts in the IDLE cycle after done, and its done is 34 cycles after that.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle divider.
//   div_state_t   : controller states
//   DIV_WIDTH     : default operand/result width
//   DIV_STEPS     : restoring steps for the default width (one per bit)
//   DIV_QUOT_FILL : fill bit of the divide-by-zero quotient (all ones)
//   DIV_REM_FILL  : fill bit of the signed-overflow remainder (all zeros)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int   DIV_WIDTH     = 32;
  localparam int   DIV_STEPS     = DIV_WIDTH;
  localparam logic DIV_QUOT_FILL = 1'b1;
  localparam logic DIV_REM_FILL  = 1'b0;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem      : current partial remainder (WIDTH+1 bits)
//   next_bit : next dividend bit, fed MSB-first
//   divisor  : divisor magnitude
//   rem_next : partial remainder after shift and trial subtract/restore
//   quot_bit : 1 when the trial subtraction was non-negative
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             quot_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Shift in the next dividend bit and trial-subtract; one extra bit keeps the borrow visible.
  always_comb begin
    shifted_s = {rem, next_bit};
    diff_s    = shifted_s - {2'b00, divisor};
    quot_bit  = ~diff_s[WIDTH+1];
    if (quot_bit) begin
      rem_next = diff_s[WIDTH:0];
    end else begin
      rem_next = shifted_s[WIDTH:0];
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed/unsigned divide and remainder controller.
// Captures operands when start is seen in IDLE, iterates div_step once per
// cycle, fixes signs, then presents the result with a one-cycle done pulse.
//   clk, reset (async, active-low)
//   start, op_signed, op_rem, dividend, divisor : request from execute stage
//   result : registered quotient or remainder, held until the next load
//   done   : one-cycle retire pulse
//   busy   : high while in RUN or FIX
//   stall  : start & ~done, holds PC and register-file write
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int STEPS = (WIDTH == DIV_WIDTH) ? DIV_STEPS : WIDTH;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [WIDTH-1:0] ZERO_V    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONE_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] QUOT_DIV0 = {WIDTH{DIV_QUOT_FILL}};
  localparam logic [WIDTH-1:0] REM_OVF   = {WIDTH{DIV_REM_FILL}};

  // Two's complement negation, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
    return ~x + ONE_V;
  endfunction

  // Magnitude of x when signed interpretation is enabled, raw x otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic en);
    if (en && x[WIDTH-1]) begin
      return neg2(x);
    end else begin
      return x;
    end
  endfunction

  div_state_t       state_r, state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   prem_r;
  logic [WIDTH-1:0] quot_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             rem_sel_r;
  logic [WIDTH-1:0] result_r;
  logic             done_r;
  logic             busy_r;

  logic             div0_s;
  logic             ovf_s;
  logic [WIDTH:0]   prem_next_s;
  logic             qbit_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  assign div0_s = (divisor == ZERO_V);
  assign ovf_s  = op_signed && (dividend == MIN_NEG_V) && (divisor == ALL_ONE_V);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (prem_r),
    .next_bit (dvd_r[WIDTH-1]),
    .divisor  (dvs_r),
    .rem_next (prem_next_s),
    .quot_bit (qbit_s)
  );

  // Sign correction applied in FIX.
  always_comb begin
    if (neg_q_r) begin
      quot_fix_s = neg2(quot_r);
    end else begin
      quot_fix_s = quot_r;
    end
    if (neg_r_r) begin
      rem_fix_s = neg2(prem_r[WIDTH-1:0]);
    end else begin
      rem_fix_s = prem_r[WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (div0_s || ovf_s) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_n = FIX;
        end else begin
          state_n = RUN;
        end
      end
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath: operand capture, restoring iteration, sign fix and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      dvd_r     <= ZERO_V;
      dvs_r     <= ZERO_V;
      prem_r    <= {(WIDTH+1){1'b0}};
      quot_r    <= ZERO_V;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      rem_sel_r <= 1'b0;
      result_r  <= ZERO_V;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= (state_n == DONE);
      busy_r <= (state_n == RUN) || (state_n == FIX);
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_r     <= mag(dividend, op_signed);
            dvs_r     <= mag(divisor, op_signed);
            neg_q_r   <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_r   <= op_signed && dividend[WIDTH-1];
            rem_sel_r <= op_rem;
            prem_r    <= {(WIDTH+1){1'b0}};
            quot_r    <= ZERO_V;
            cnt_r     <= CNT_W'(STEPS - 1);
            // Special cases bypass the iteration and load the result directly.
            if (div0_s) begin
              result_r <= op_rem ? dividend : QUOT_DIV0;
            end else if (ovf_s) begin
              result_r <= op_rem ? REM_OVF : dividend;
            end else begin
              result_r <= result_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          prem_r <= prem_next_s;
          quot_r <= {quot_r[WIDTH-2:0], qbit_s};
          dvd_r  <= {dvd_r[WIDTH-2:0], 1'b0};
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        FIX: begin
          result_r <= rem_sel_r ? rem_fix_s : quot_fix_s;
        end
        DONE: begin
          result_r <= result_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign result = result_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign stall  = start & ~done_r;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer (WIDTH=32).
module tb_div_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_signed;
  logic        op_rem;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  int n_cmp;
  int n_bad;

  div_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_signed (op_signed),
    .op_rem    (op_rem),
    .dividend  (dividend),
    .divisor   (divisor),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation starting at a negedge; cycle 0 is the cycle ending at the next posedge.
  task automatic run_op(input string tag, input logic sg, input logic rm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc);
    int  cyc;
    int  stall_hi;
    bit  seen;
    logic busy1;
    op_signed = sg;
    op_rem    = rm;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    #1;
    cyc      = 0;
    seen     = 1'b0;
    busy1    = 1'b0;
    stall_hi = (stall === 1'b1) ? 1 : 0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) busy1 = busy;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else if (stall === 1'b1) begin
        stall_hi++;
      end
    end
    chk({tag, "_done_cycle"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
    chk({tag, "_stall_cycles"}, 32'(stall_hi), 32'(exp_cyc));
    chk({tag, "_busy_cycle1"}, {31'd0, busy1}, (exp_cyc > 1) ? 32'd1 : 32'd0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse_once"}, {31'd0, done}, 32'd0);
    chk({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    int   cyc;
    int   nd;
    int   dcyc [2];
    logic [31:0] dres [2];
    logic stall35;

    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    start     = 1'b0;
    op_signed = 1'b0;
    op_rem    = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;

    // Reset state.
    #2;
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    start = 1'b1;
    #1;
    chk("rst_stall_start", {31'd0, stall}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("udiv_100_7",  1'b0, 1'b0, 32'd100,       32'd7,          32'h0000_000E, 34);
    run_op("urem_100_7",  1'b0, 1'b1, 32'd100,       32'd7,          32'h0000_0002, 34);
    run_op("sdiv_m100_7", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2, 34);
    run_op("srem_m100_7", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE, 34);
    run_op("sdiv_100_m7", 1'b1, 1'b0, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 34);
    run_op("udiv_big",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000,  32'h0000_FFFF, 34);
    run_op("div0_q",      1'b0, 1'b0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 1);
    run_op("div0_r",      1'b0, 1'b1, 32'h1234_5678, 32'd0,          32'h1234_5678, 1);
    run_op("ovf_q",       1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1);
    run_op("ovf_r",       1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 1);
    run_op("udiv_80000000_m1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);

    // Operand changes during RUN with start held high: back-to-back operations.
    op_signed = 1'b0;
    op_rem    = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    cyc       = 0;
    nd        = 0;
    dcyc[0]   = -1;
    dcyc[1]   = -1;
    dres[0]   = 32'd0;
    dres[1]   = 32'd0;
    stall35   = 1'b0;
    while (nd < 2 && cyc < 120) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 5) begin
        dividend  = 32'd9;
        divisor   = 32'd3;
        op_signed = 1'b1;
      end
      if (cyc == 35) stall35 = stall;
      if (done === 1'b1) begin
        dcyc[nd] = cyc;
        dres[nd] = result;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_first_cycle", 32'(dcyc[0]), 32'd34);
    chk("b2b_first_result", dres[0], 32'h0000_000E);
    chk("b2b_stall_recapture", {31'd0, stall35}, 32'd1);
    chk("b2b_second_cycle", 32'(dcyc[1]), 32'd69);
    chk("b2b_second_result", dres[1], 32'h0000_0003);
    @(negedge clk);

    // Reset asserted in cycle 10 of a 100/7 run.
    op_signed = 1'b0;
    op_rem    = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    cyc       = 0;
    while (cyc < 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("mid_reset_result", result, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("after_reset_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'h0000_0003, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
